kd_point_feeder: RTL

// Upstream driver of the kd-tree root cluster_node. Sequences one k-means iteration:

---
 rtl/kd_tree_pkg.sv | 23 ++
 rtl/kd_skid_buffer.sv | 51 +++++
 rtl/kd_point_feeder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/kd_tree_pkg.sv
// Shared sizing constants and feeder state encoding for the kd-tree k-means datapath.
package kd_tree_pkg;

    localparam int DIM        = 3;
    localparam int DATA_RANGE = 255;
    localparam int MAX_N      = 1000;
    localparam int MAX_ITER   = 16;

    localparam int DIM_SIZE     = $clog2(DATA_RANGE);
    localparam int CENTER_SIZE  = DIM * DIM_SIZE;
    localparam int COUNTER_SIZE = $clog2(MAX_N);
    localparam int AXIS_SIZE    = $clog2(DIM);
    localparam int DEPTH_SIZE   = $clog2(MAX_N);
    localparam int ITER_SIZE    = $clog2(MAX_ITER + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SORT   = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/kd_skid_buffer.sv
// Two-entry valid/ready FIFO absorbing one-cycle-late memory read data.
// Latency: a pushed word is visible at the head on the following cycle.
// Backpressure: head is held while i_rdy is low; writer must respect o_count.
module kd_skid_buffer
    import kd_tree_pkg::*;
#(
    parameter int WIDTH = CENTER_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    input  logic             i_rdy,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_vld && (r_cnt != 2'd2);
    assign w_pop   = (r_cnt != 2'd0) && i_rdy;
    assign o_vld   = (r_cnt != 2'd0);
    assign o_dat   = r_mem[r_rptr];
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_dat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/kd_point_feeder.sv
// Sequences k-means iterations: sort the tree, stream every point into the root, drain, repeat.
// Latency: first point reaches point_out two cycles after STREAM entry, then one per cycle.
// Backpressure: point_ready low holds point_out/point_valid; reads are throttled to buffer space.
module kd_point_feeder
    import kd_tree_pkg::*;
#(
    parameter int dim        = DIM,
    parameter int data_range = DATA_RANGE,
    parameter int max_n      = MAX_N,
    parameter int max_iter   = MAX_ITER
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [$clog2(max_n)-1:0]                    n_points,
    output logic                                        mem_rd_en,
    output logic [$clog2(max_n)-1:0]                    mem_addr,
    input  logic [dim*$clog2(data_range)-1:0]           mem_data,
    output logic                                        en,
    output logic                                        sorting,
    input  logic                                        root_sort_done,
    output logic [dim*$clog2(data_range)-1:0]           point_out,
    output logic                                        point_valid,
    input  logic                                        point_ready,
    input  logic                                        tree_idle,
    input  logic                                        converged,
    output logic [$clog2(max_iter+1)-1:0]               iter_count,
    output logic                                        busy,
    output logic                                        done
);

    localparam int DS = $clog2(data_range);
    localparam int CS = dim * DS;
    localparam int NS = $clog2(max_n);
    localparam int IS = $clog2(max_iter + 1);

    logic [2:0]    r_state;
    logic [NS-1:0] r_n;
    logic [NS-1:0] r_addr;
    logic          r_rd_all;
    logic          r_inflight;
    logic [IS-1:0] r_iter;

    logic          w_stream;
    logic          w_buf_vld;
    logic [CS-1:0] w_buf_dat;
    logic [1:0]    w_buf_cnt;
    logic          w_pop;
    logic [2:0]    w_pending;
    logic          w_issue;
    logic          w_last_pop;
    logic [IS-1:0] w_iter_nxt;

    assign w_stream = (r_state == ST_STREAM);
    assign w_pop    = w_stream && w_buf_vld && point_ready;

    // Counting this cycle's pop lets a read go out every cycle under full-rate ready.
    assign w_pending  = {1'b0, w_buf_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue    = w_stream && !r_rd_all && (w_pending < 3'd2);

    // With every read issued and nothing in flight, a lone buffered word is point n-1.
    assign w_last_pop = w_pop && r_rd_all && !r_inflight && (w_buf_cnt == 2'd1);
    assign w_iter_nxt = r_iter + 1'b1;

    kd_skid_buffer #(
        .WIDTH (CS)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (r_inflight),
        .i_dat   (mem_data),
        .o_vld   (w_buf_vld),
        .o_dat   (w_buf_dat),
        .i_rdy   (point_ready && w_stream),
        .o_count (w_buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_addr     <= '0;
            r_rd_all   <= 1'b0;
            r_inflight <= 1'b0;
            r_iter     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                if (r_addr == r_n - 1'b1) begin
                    r_rd_all <= 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_iter   <= '0;
                        r_addr   <= '0;
                        r_rd_all <= 1'b0;
                        if (n_points != '0) begin
                            r_n     <= n_points;
                            r_state <= ST_SORT;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SORT: begin
                    if (root_sort_done) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_last_pop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (tree_idle) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_iter <= w_iter_nxt;
                    if (converged || (w_iter_nxt == IS'(max_iter))) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state  <= ST_SORT;
                        r_addr   <= '0;
                        r_rd_all <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en   = w_issue;
    assign mem_addr    = r_addr;
    assign en          = (r_state == ST_SORT) || w_stream || (r_state == ST_DRAIN);
    assign sorting     = (r_state == ST_SORT);
    assign point_out   = w_buf_dat;
    assign point_valid = w_stream && w_buf_vld;
    assign iter_count  = r_iter;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

endmodule
